// File: rtl/shift_seq_n_pkg.sv
// Shared definitions for the sequential shift/rotate engine: shift mode
// encoding and FSM state encoding.
package shift_seq_pkg;

  // One-step shift modes, as presented on the mode input
  typedef enum logic [2:0] {
    MODE_SLL    = 3'd0,  // shift left, LSB <= 0
    MODE_SRL    = 3'd1,  // shift right, MSB <= 0
    MODE_SRA    = 3'd2,  // shift right, MSB kept
    MODE_ROL    = 3'd3,  // rotate left
    MODE_ROR    = 3'd4,  // rotate right
    MODE_SL_SER = 3'd5,  // shift left, LSB <= ser_in
    MODE_SR_SER = 3'd6,  // shift right, MSB <= ser_in
    MODE_RSV    = 3'd7   // reserved: vector holds
  } mode_e;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq_n_if.sv
// Request/result bundle of the shift engine. The requester drives the
// operand side, the engine drives the result side.
interface shift_seq_n_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amt, din, ser_in,
    input  dout, ser_out, busy, done
  );

  modport slave (
    input  start, mode, amt, din, ser_in,
    output dout, ser_out, busy, done
  );
endinterface

// File: rtl/shift_seq_n_step.sv
// Combinational single-position shift/rotate for one engine step.
// out_bit is the bit leaving the vector (MSB for left moves, LSB for
// right moves); the reserved mode passes the vector through unchanged.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] vec,
  input  mode_e            mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_vec,
  output logic             out_bit
);

  // Select the one-step result and the departing bit for the current mode
  always_comb begin
    next_vec = vec;
    out_bit  = 1'b0;
    case (mode)
      MODE_SLL: begin
        next_vec = {vec[WIDTH-2:0], 1'b0};
        out_bit  = vec[WIDTH-1];
      end
      MODE_SRL: begin
        next_vec = {1'b0, vec[WIDTH-1:1]};
        out_bit  = vec[0];
      end
      MODE_SRA: begin
        next_vec = {vec[WIDTH-1], vec[WIDTH-1:1]};
        out_bit  = vec[0];
      end
      MODE_ROL: begin
        next_vec = {vec[WIDTH-2:0], vec[WIDTH-1]};
        out_bit  = vec[WIDTH-1];
      end
      MODE_ROR: begin
        next_vec = {vec[0], vec[WIDTH-1:1]};
        out_bit  = vec[0];
      end
      MODE_SL_SER: begin
        next_vec = {vec[WIDTH-2:0], ser_in};
        out_bit  = vec[WIDTH-1];
      end
      MODE_SR_SER: begin
        next_vec = {ser_in, vec[WIDTH-1:1]};
        out_bit  = vec[0];
      end
      default: begin
        next_vec = vec;
        out_bit  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_n.sv
// Multi-cycle shift/rotate engine: loads an operand on start, applies one
// shift step per clock for amt clocks, then pulses done for one cycle.
module shift_seq_n
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  shift_seq_n_if.slave bus
);

  state_e           state_reg;
  mode_e            mode_reg;
  logic [AMT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             ser_out_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] step_vec;
  logic             step_bit;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .vec      (dout_reg),
    .mode     (mode_reg),
    .ser_in   (bus.ser_in),
    .next_vec (step_vec),
    .out_bit  (step_bit)
  );

  // Sequencer: capture on start, step until the count expires, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mode_reg    <= MODE_SLL;
      cnt_reg     <= '0;
      dout_reg    <= '0;
      ser_out_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            dout_reg <= bus.din;
            mode_reg <= mode_e'(bus.mode);
            busy_reg <= 1'b1;
            if (bus.amt == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= SHIFT;
              cnt_reg   <= bus.amt;
            end
          end
        end
        SHIFT: begin
          dout_reg <= step_vec;
          // Reserved mode moves nothing, so the serial output keeps its value
          if (mode_reg != MODE_RSV) begin
            ser_out_reg <= step_bit;
          end
          cnt_reg <= cnt_reg - AMT_W'(1);
          if (cnt_reg == AMT_W'(1)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout    = dout_reg;
  assign bus.ser_out = ser_out_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_shift_seq_n.sv
// Directed bench for shift_seq_n at WIDTH=8 with hand-computed results.
module tb_shift_seq_n;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   busy_n;
  int   done_n;
  int   done_idx;

  shift_seq_n_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_seq_n #(.WIDTH(8), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it until the engine is idle again.
  // Sample index i is the falling edge after rising edge k+i (k = start edge).
  task automatic run_op(input logic [2:0] m, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] spat, input bit hold,
                        output int b_n, output int d_n, output int d_idx);
    b_n   = 0;
    d_n   = 0;
    d_idx = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    bus.din   = d;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.din = ~d;
    for (int i = 0; i < 40; i++) begin
      if (!(bus.busy || bus.done)) break;
      if (bus.busy) b_n++;
      if (bus.done) begin
        d_n++;
        if (d_idx < 0) d_idx = i;
      end
      bus.ser_in = (i < 8) ? spat[i] : 1'b0;
      @(negedge clk);
    end
    bus.start  = 1'b0;
    bus.ser_in = 1'b0;
    $display("op mode=%0d amt=%0d din=%02h -> dout=%02h ser_out=%0b busy_cycles=%0d done_at=%0d",
             m, a, d, bus.dout, bus.ser_out, b_n, d_idx);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.mode   = 3'd0;
    bus.amt    = 3'd0;
    bus.din    = 8'h00;
    bus.ser_in = 1'b0;
    #1;
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_ser_out", 32'(bus.ser_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SRL by 3: B4 -> 16, last bit out is 1
    run_op(3'd1, 3'd3, 8'hB4, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("srl_dout", 32'(bus.dout), 32'h16);
    check("srl_ser_out", 32'(bus.ser_out), 32'h1);
    check("srl_busy_cycles", 32'(busy_n), 32'd4);
    check("srl_done_count", 32'(done_n), 32'd1);
    check("srl_done_idx", 32'(done_idx), 32'd3);

    // SRA by 2: 90 -> E4
    run_op(3'd2, 3'd2, 8'h90, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("sra_dout", 32'(bus.dout), 32'hE4);
    check("sra_ser_out", 32'(bus.ser_out), 32'h0);
    check("sra_done_idx", 32'(done_idx), 32'd2);

    // ROL by 4: A5 -> 5A
    run_op(3'd3, 3'd4, 8'hA5, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("rol_dout", 32'(bus.dout), 32'h5A);
    check("rol_ser_out", 32'(bus.ser_out), 32'h0);

    // Serial right with ser_in 1,0,1,1: 00 -> D0
    run_op(3'd6, 3'd4, 8'h00, 8'h0D, 1'b0, busy_n, done_n, done_idx);
    check("srser_dout", 32'(bus.dout), 32'hD0);
    check("srser_ser_out", 32'(bus.ser_out), 32'h0);

    // SLL by 7: FF -> 80, last bit out is 1
    run_op(3'd0, 3'd7, 8'hFF, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("sll7_dout", 32'(bus.dout), 32'h80);
    check("sll7_ser_out", 32'(bus.ser_out), 32'h1);
    check("sll7_done_idx", 32'(done_idx), 32'd7);

    // amt=0: done right after the start edge, ser_out untouched
    run_op(3'd1, 3'd0, 8'h3C, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("amt0_dout", 32'(bus.dout), 32'h3C);
    check("amt0_ser_out", 32'(bus.ser_out), 32'h1);
    check("amt0_done_idx", 32'(done_idx), 32'd0);
    check("amt0_busy_cycles", 32'(busy_n), 32'd1);

    // Reserved mode: operand holds, latency unchanged
    run_op(3'd7, 3'd5, 8'h5A, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("rsv_dout", 32'(bus.dout), 32'h5A);
    check("rsv_done_idx", 32'(done_idx), 32'd5);
    check("rsv_busy_cycles", 32'(busy_n), 32'd6);

    // start held through SHIFT and DONE: no recapture of the changed din
    run_op(3'd1, 3'd3, 8'hB4, 8'h00, 1'b1, busy_n, done_n, done_idx);
    check("hold_dout", 32'(bus.dout), 32'h16);
    check("hold_done_count", 32'(done_n), 32'd1);
    @(negedge clk);
    check("hold_idle_busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset after two SRL steps of an amt=6 operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 3'd1;
    bus.amt   = 3'd6;
    bus.din   = 8'hF0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_dout_before_rst", 32'(bus.dout), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.dout), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    $display("async reset mid-shift: dout=%02h busy=%0b done=%0b", bus.dout, bus.busy, bus.done);
    @(negedge clk);
    rst_n  = 1'b1;
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("post_rst_no_done", 32'(done_n), 32'd0);

    // Normal operation after reset release: SRL by 1, 03 -> 01
    run_op(3'd1, 3'd1, 8'h03, 8'h00, 1'b0, busy_n, done_n, done_idx);
    check("after_rst_dout", 32'(bus.dout), 32'h01);
    check("after_rst_ser_out", 32'(bus.ser_out), 32'h1);
    check("after_rst_done_idx", 32'(done_idx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
